// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Purpose:
//   * Detects load-use hazards between ID and EX. It inserts exactly one
//     bubble by holding IF/ID and flushing the EX stage register.
//   * Handles taken-branch and jump redirects by flushing ID and EX.
//     A redirect takes priority over a load-use hazard.
//   * Optional multi-cycle mul/div sequencing. It keeps a mul/div in EX for
//     MD_LAT cycles in total, including the start cycle. During that time
//     it holds IF/ID/EX, feeds bubbles into MEM, and pulses mdDone on the
//     last cycle.
//
// Configuration macro:
//   HAZARD_MULDIV_EN -- when defined, the mul/div sequencer (MD_BUSY state
//   and down-counter) is built. When undefined, mdStart is ignored and
//   stallEX, flushMEM, mdBusy and mdDone are tied to 0.
//
// Parameter:
//   MD_LAT   mul/div latency in cycles, legal range 2..32 (default 8)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset; forces all outputs to 0
//   idValid      in   ID holds a valid instruction
//   idRs1/idRs2  in   ID source register numbers (5 bits each)
//   idRs1Used/idRs2Used in  source actually read by the ID instruction
//   exRd         in   EX destination register
//   exMemRead    in   EX instruction is a load
//   branchTaken  in   EX redirect (taken branch or jump)
//   mdStart      in   EX instruction is a multi-cycle mul/div
//   stallIF/stallID/stallEX   out  hold the stage register
//   flushID/flushEX/flushMEM  out  insert a bubble into the stage register
//   mdBusy       out  mul/div sequence in progress
//   mdDone       out  one-cycle pulse on the last busy cycle
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MD_LAT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idValid,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic       idRs1Used,
  input  logic       idRs2Used,
  input  logic [4:0] exRd,
  input  logic       exMemRead,
  input  logic       branchTaken,
  input  logic       mdStart,
  output logic       stallIF,
  output logic       stallID,
  output logic       stallEX,
  output logic       flushID,
  output logic       flushEX,
  output logic       flushMEM,
  output logic       mdBusy,
  output logic       mdDone
);

  // A load into x0 never produces a value, so it can never cause a stall.
  logic load_use;
  assign load_use = idValid & exMemRead & (exRd != 5'd0) &
                    ((idRs1Used & (idRs1 == exRd)) |
                     (idRs2Used & (idRs2 == exRd)));

`ifdef HAZARD_MULDIV_EN
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The start cycle is one EX cycle, so MD_BUSY lasts MD_LAT-1 cycles.
  // The counter therefore starts at MD_LAT-2 and MD_BUSY ends when it
  // reaches 0.
  localparam logic [4:0] MD_CNT_INIT = 5'(MD_LAT - 2);

  state_t     state_q, state_d;
  logic [4:0] md_cnt_q, md_cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (mdStart) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == 5'd0) begin
          state_d  = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 5'd1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = 5'd0;
      end
    endcase
  end
`else
  // Without the sequencer, clk and mdStart have no function.
  logic unused_md;
  assign unused_md = &{1'b0, clk, mdStart};
`endif

  // Output logic. Outputs are gated by reset so that a sequence aborted
  // by reset shows nothing (in particular, no mdDone).
  always_comb begin
    stallIF  = 1'b0;
    stallID  = 1'b0;
    stallEX  = 1'b0;
    flushID  = 1'b0;
    flushEX  = 1'b0;
    flushMEM = 1'b0;
    mdBusy   = 1'b0;
    mdDone   = 1'b0;
    if (!reset) begin
`ifdef HAZARD_MULDIV_EN
      if (state_q == MD_BUSY) begin
        // Front end stays frozen. EX is released on the final cycle so
        // that the result advances.
        stallIF  = 1'b1;
        stallID  = 1'b1;
        stallEX  = (md_cnt_q != 5'd0);
        flushMEM = 1'b1;
        mdBusy   = 1'b1;
        mdDone   = (md_cnt_q == 5'd0);
      end else if (mdStart) begin
        stallIF  = 1'b1;
        stallID  = 1'b1;
        stallEX  = 1'b1;
        flushMEM = 1'b1;
      end else
`endif
      if (branchTaken) begin
        flushID = 1'b1;
        flushEX = 1'b1;
      end else if (load_use) begin
        stallIF = 1'b1;
        stallID = 1'b1;
        flushEX = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Each cycle checks the outputs against a behavioural model. The model
// tracks the number of mul/div busy cycles that remain. Some cycles also
// check hand-computed literal expectations.
// Output vector bit order:
//   {stallIF, stallID, stallEX, flushID, flushEX, flushMEM, mdBusy, mdDone}
module tb_hazard_ctrl;

`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int LAT = 8;

  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_BR    = 8'b0001_1000;
  localparam logic [7:0] O_START = 8'b1110_0100;
  localparam logic [7:0] O_BUSY  = 8'b1110_0110;
  localparam logic [7:0] O_DONE  = 8'b1100_0111;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid, idRs1Used, idRs2Used, exMemRead, branchTaken, mdStart;
  logic [4:0] idRs1, idRs2, exRd;
  logic       stallIF, stallID, stallEX, flushID, flushEX, flushMEM, mdBusy, mdDone;
  logic [7:0] outs;

  int checks   = 0;
  int failures = 0;
  int md_left  = 0;   // model: remaining MD_BUSY cycles

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idRs1(idRs1), .idRs2(idRs2), .idRs1Used(idRs1Used), .idRs2Used(idRs2Used),
    .exRd(exRd), .exMemRead(exMemRead), .branchTaken(branchTaken), .mdStart(mdStart),
    .stallIF(stallIF), .stallID(stallID), .stallEX(stallEX),
    .flushID(flushID), .flushEX(flushEX), .flushMEM(flushMEM),
    .mdBusy(mdBusy), .mdDone(mdDone)
  );

  assign outs = {stallIF, stallID, stallEX, flushID, flushEX, flushMEM, mdBusy, mdDone};

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, req);
    end
  endtask

  // ID reads a register that the load in EX is writing (x0 never counts).
  function automatic bit model_load_use();
    bit hit = 1'b0;
    if (idRs1Used && idRs1 == exRd) hit = 1'b1;
    if (idRs2Used && idRs2 == exRd) hit = 1'b1;
    return idValid && exMemRead && (exRd != 0) && hit;
  endfunction

  function automatic logic [7:0] model_out();
    if (reset)                  return O_NONE;
    if (md_left > 1)            return O_BUSY;
    if (md_left == 1)           return O_DONE;
    if (MD_EN && mdStart)       return O_START;
    if (branchTaken)            return O_BR;
    if (model_load_use())       return O_LU;
    return O_NONE;
  endfunction

  // Model state: a mul/div holds EX for LAT cycles in total, so LAT-1
  // busy cycles follow the start cycle.
  always @(posedge clk) begin
    if (reset)                   md_left <= 0;
    else if (md_left > 0)        md_left <= md_left - 1;
    else if (MD_EN && mdStart)   md_left <= LAT - 1;
  end

  // Compare process: every cycle, mid-period
  always @(negedge clk) check("model", outs, model_out());

  // Checks a literal expectation at the next negedge, then lets the
  // rising edge pass.
  task automatic tick(input bit lit, input logic [7:0] exp_v, input string nm);
    @(negedge clk);
    if (lit) check(nm, outs, exp_v);
    @(posedge clk);
    #1;
    $display("cycle %s outs=%b", nm, outs);
  endtask

  task automatic idle();
    reset = 1'b0; idValid = 1'b0; idRs1 = 5'd0; idRs2 = 5'd0;
    idRs1Used = 1'b0; idRs2Used = 1'b0; exRd = 5'd0; exMemRead = 1'b0;
    branchTaken = 1'b0; mdStart = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    idValid = 1'b1; exMemRead = 1'b1; exRd = rd;
    idRs2 = 5'd5; idRs2Used = 1'b1; idRs1 = 5'd9; idRs1Used = 1'b1;
  endtask

  // Full mul/div sequence, with hazards presented during the busy cycles
  // to show that they are ignored.
  task automatic md_sequence(input string tag);
    idle(); mdStart = 1'b1; branchTaken = 1'b1;
    tick(1'b1, O_START, {tag, "_start"});
    mdStart = 1'b0;
    for (int i = 1; i < LAT - 1; i++) begin
      if (i == 2) set_load_use(5'd5);
      tick(1'b1, O_BUSY, {tag, "_busy"});
    end
    tick(1'b1, O_DONE, {tag, "_done"});
    idle();
    tick(1'b1, O_NONE, {tag, "_run"});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    set_load_use(5'd5);
    tick(1'b1, O_NONE, "reset_gate");
    tick(1'b1, O_NONE, "reset_gate2");
    idle();
    tick(1'b1, O_NONE, "idle");

    set_load_use(5'd5);
    tick(1'b1, O_LU, "lu_rs2");
    idle();
    tick(1'b1, O_NONE, "lu_one_bubble");

    set_load_use(5'd9); idRs1Used = 1'b0;
    tick(1'b1, O_NONE, "rs1_unused");
    idRs1Used = 1'b1;
    tick(1'b1, O_LU, "lu_rs1");
    exMemRead = 1'b0;
    tick(1'b1, O_NONE, "no_load");

    set_load_use(5'd0); idRs2 = 5'd0;
    tick(1'b1, O_NONE, "x0_no_stall");

    set_load_use(5'd5); branchTaken = 1'b1;
    tick(1'b1, O_BR, "branch_over_lu");
    idValid = 1'b0;
    tick(1'b1, O_BR, "branch_only");
    branchTaken = 1'b0;
    tick(1'b1, O_NONE, "id_invalid");

    if (MD_EN) begin
      md_sequence("md");
      // Reset arrives on the 3rd MD_BUSY cycle.
      idle(); mdStart = 1'b1;
      tick(1'b1, O_START, "abort_start");
      mdStart = 1'b0;
      tick(1'b1, O_BUSY, "abort_busy1");
      tick(1'b1, O_BUSY, "abort_busy2");
      reset = 1'b1;
      tick(1'b1, O_NONE, "abort_reset");
      reset = 1'b0;
      tick(1'b1, O_NONE, "abort_no_done");
      md_sequence("md_fresh");
    end else begin
      idle(); mdStart = 1'b1;
      tick(1'b1, O_NONE, "md_ignored");
      set_load_use(5'd5);
      tick(1'b1, O_LU, "md_ignored_lu");
      idle();
      tick(1'b1, O_NONE, "md_off_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: MD_LAT, default 8, multi-cycle mul/div latency in cycles (legal range 2..32).
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- idValid  in  1  ID holds a valid instruction
- idRs1, idRs2  in  5 each  ID source register numbers
- idRs1Used, idRs2Used  in  1 each  source actually read
- exRd  in  5  EX destination register
- exMemRead  in  1  EX instruction is a load
- branchTaken  in  1  EX redirect (taken branch or jump)
- mdStart  in  1  EX instruction is a multi-cycle mul/div
- stallIF, stallID, stallEX  out  1 each  hold stage register
- flushID, flushEX, flushMEM  out  1 each  insert bubble into stage register; flushEX also drives the forwarding unit's flush input
- mdBusy  out  1  mul/div sequence in progress
- mdDone  out  1  one-cycle pulse on the last busy cycle

Function
REQ-003 The FSM SHALL have two states: RUN and MD_BUSY, plus a 5-bit down-counter mdCnt.
REQ-004 In RUN, loadUse SHALL equal idValid & exMemRead & (exRd!=0) & ((idRs1Used & idRs1==exRd) | (idRs2Used & idRs2==exRd)).
REQ-005 In RUN with loadUse=1 and branchTaken=0, the block SHALL assert stallIF=stallID=flushEX=1 in the same cycle (zero-latency, combinational), giving exactly one bubble per load-use pair.
REQ-006 In RUN with branchTaken=1, the block SHALL assert flushID=flushEX=1 and SHALL deassert all stalls; branchTaken SHALL take priority over loadUse.
REQ-007 In RUN with mdStart=1, the block SHALL take precedence over branchTaken and loadUse, SHALL go to MD_BUSY on the next edge, and SHALL load mdCnt=MD_LAT-2.
REQ-008 In the mdStart cycle, the block SHALL assert stallIF=stallID=stallEX=1 and flushMEM=1.
REQ-009 In MD_BUSY, the block SHALL assert stallIF=stallID=stallEX=flushMEM=mdBusy=1 and ignore branchTaken and loadUse; mdCnt SHALL decrement each cycle.
REQ-010 In MD_BUSY with mdCnt==0, the block SHALL assert mdDone=1 and stallEX=0 (the result advances), and SHALL return to RUN on the next edge.
REQ-011 Total EX occupancy of a mul/div SHALL be exactly MD_LAT cycles, including the mdStart cycle.
REQ-012 With MD_LAT=2, MD_BUSY SHALL last one cycle, with mdDone asserted in that cycle.
REQ-013 Every output not explicitly asserted by REQ-005 to REQ-010 SHALL be 0.
REQ-014 exRd==0 SHALL never cause a stall.

Reset
REQ-015 When reset=1 at a rising edge, the FSM SHALL enter RUN and mdCnt SHALL clear to 0.
REQ-016 While reset=1, all outputs SHALL be 0, including when reset arrives mid-MD_BUSY; no mdDone is issued for an aborted sequence.

Configuration
REQ-017 With macro HAZARD_MULDIV_EN defined, the block SHALL implement REQ-007 to REQ-012.
REQ-018 With HAZARD_MULDIV_EN undefined, the block SHALL ignore mdStart, tie stallEX, flushMEM, mdBusy and mdDone to 0, and omit the MD_BUSY state and counter; load-use and branch behaviour SHALL be unchanged.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- exMemRead=1, exRd=5, idRs2=5, idRs2Used=1, idValid=1 -> stallIF=stallID=flushEX=1 for exactly that cycle.
- Same as above but exRd=0 -> all outputs 0.
- Load-use condition and branchTaken=1 in the same cycle -> flushID=flushEX=1, stallIF=stallID=0.
- MD_LAT=8, mdStart pulse -> stallIF=1 for 8 consecutive cycles, mdDone=1 only on the 8th, stallEX=0 on the 8th, then RUN.
- reset=1 on the 3rd MD_BUSY cycle -> next cycle all outputs 0, no mdDone, and a fresh mdStart takes the full 8 cycles.
- Build without HAZARD_MULDIV_EN, mdStart=1 -> no stall, mdBusy=0.
